// File: rtl/ballot_tally_collector.sv
// Ballot collection front end: accepts one ballot per voter, keeps per-candidate
// tallies, then runs a one-candidate-per-cycle max search and offers the winner.
module ballot_tally_collector #(
    parameter int N_VOTERS = 16,
    parameter int CAND_W   = 2,
    parameter int CNT_W    = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         ballot_valid,
    output logic                         ballot_ready,
    input  logic [3:0]                   ballot_voter,
    input  logic [CAND_W-1:0]            ballot_data,
    output logic                         ballot_reject,
    output logic                         result_valid,
    input  logic                         result_ready,
    output logic [CAND_W-1:0]            winner,
    output logic [CNT_W-1:0]             winner_votes,
    output logic [N_VOTERS*CAND_W-1:0]   ballots_packed,
    output logic                         busy
);

    localparam int N_CAND = 2 ** CAND_W;

    typedef enum logic [1:0] {IDLE, COLLECT, COMPARE, DONE} state_t;

    state_t              state_reg, state_next;
    logic [CAND_W-1:0]   k_reg, k_next;
    logic [N_VOTERS-1:0] voted_reg;
    logic [CNT_W-1:0]    tally_reg [N_CAND];
    logic [CAND_W-1:0]   slot_reg  [N_VOTERS];
    logic [CAND_W-1:0]   winner_reg;
    logic [CNT_W-1:0]    votes_reg;
    logic                reject_reg;

    logic                in_range;
    logic [N_VOTERS-1:0] voter_onehot;
    logic                fresh;
    logic                ballot_hs;
    logic                accept;
    logic                last_ballot;
    logic                open_election;
    logic                clear_votes;

    // Ready is withheld during abort so an aborted cycle never completes a handshake.
    assign ballot_ready  = (state_reg == COLLECT) && !abort;
    assign ballot_hs     = ballot_valid && ballot_ready;
    assign result_valid  = (state_reg == DONE);
    assign busy          = (state_reg != IDLE);
    assign ballot_reject = reject_reg;
    assign winner        = winner_reg;
    assign winner_votes  = votes_reg;
    assign open_election = (state_reg == IDLE) && start && !abort;
    assign clear_votes   = abort || open_election;

    always_comb begin
        in_range     = ({1'b0, ballot_voter} < 5'(N_VOTERS));
        voter_onehot = '0;
        if (in_range) begin
            voter_onehot[ballot_voter] = 1'b1;
        end
        fresh       = in_range && ((voted_reg & voter_onehot) == '0);
        accept      = ballot_hs && fresh;
        last_ballot = accept && ((voted_reg | voter_onehot) == '1);
    end

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_next = COLLECT;
                    end
                end
                COLLECT: begin
                    if (last_ballot) begin
                        state_next = COMPARE;
                        k_next     = '0;
                    end
                end
                COMPARE: begin
                    k_next = k_reg + 1'b1;
                    if (k_reg == CAND_W'(N_CAND - 1)) begin
                        state_next = DONE;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            k_reg      <= '0;
            voted_reg  <= '0;
            reject_reg <= 1'b0;
            winner_reg <= '0;
            votes_reg  <= '0;
            for (int i = 0; i < N_CAND; i++) begin
                tally_reg[i] <= '0;
            end
            for (int i = 0; i < N_VOTERS; i++) begin
                slot_reg[i] <= '0;
            end
        end else begin
            state_reg  <= state_next;
            k_reg      <= k_next;
            reject_reg <= ballot_hs && !fresh;

            if (clear_votes) begin
                voted_reg <= '0;
                for (int i = 0; i < N_CAND; i++) begin
                    tally_reg[i] <= '0;
                end
            end else if (accept) begin
                voted_reg              <= voted_reg | voter_onehot;
                tally_reg[ballot_data] <= tally_reg[ballot_data] + 1'b1;
            end

            // Slots survive an abort; only a fresh election wipes them.
            if (open_election) begin
                for (int i = 0; i < N_VOTERS; i++) begin
                    slot_reg[i] <= '0;
                end
            end else if (accept) begin
                slot_reg[ballot_voter] <= ballot_data;
            end

            // Strict greater-than keeps the lowest index on ties.
            if (state_reg == COMPARE && !abort) begin
                if (k_reg == '0) begin
                    winner_reg <= '0;
                    votes_reg  <= tally_reg[0];
                end else if (tally_reg[k_reg] > votes_reg) begin
                    winner_reg <= k_reg;
                    votes_reg  <= tally_reg[k_reg];
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_VOTERS; gi++) begin : g_pack
            assign ballots_packed[gi*CAND_W +: CAND_W] = slot_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_ballot_tally_collector.sv
// Randomized and directed bench for ballot_tally_collector; a per-voter ballot model
// predicts handshakes, rejects, result timing and the winner.
module tb_ballot_tally_collector;

    localparam int NV = 16;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, ballot_valid, ballot_ready;
    logic [3:0]  ballot_voter;
    logic [1:0]  ballot_data;
    logic        ballot_reject, result_valid, result_ready;
    logic [1:0]  winner;
    logic [4:0]  winner_votes;
    logic [31:0] ballots_packed;
    logic        busy;

    always #5 clk = ~clk;

    ballot_tally_collector dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .ballot_valid   (ballot_valid),
        .ballot_ready   (ballot_ready),
        .ballot_voter   (ballot_voter),
        .ballot_data    (ballot_data),
        .ballot_reject  (ballot_reject),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .winner         (winner),
        .winner_votes   (winner_votes),
        .ballots_packed (ballots_packed),
        .busy           (busy)
    );

    int checks   = 0;
    int failures = 0;

    bit         voted [NV];
    logic [1:0] slot  [NV];
    int         cnt   [4];
    bit exp_ready, exp_busy, exp_valid, exp_reject;
    bit chk_en  = 1'b0;
    bit chk_out = 1'b0;
    int mw, mv;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int n_voted();
        int n = 0;
        for (int i = 0; i < NV; i++) n += int'(voted[i]);
        return n;
    endfunction

    function automatic logic [31:0] model_packed();
        logic [31:0] p = '0;
        for (int i = 0; i < NV; i++) p[2*i +: 2] = slot[i];
        return p;
    endfunction

    function automatic void model_winner(output int w, output int v);
        w = 0;
        v = cnt[0];
        for (int c = 1; c < 4; c++) begin
            if (cnt[c] > v) begin
                w = c;
                v = cnt[c];
            end
        end
    endfunction

    function automatic void clear_votes_model();
        for (int i = 0; i < NV; i++) voted[i] = 1'b0;
        for (int c = 0; c < 4; c++) cnt[c] = 0;
    endfunction

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("ballot_ready", ballot_ready, exp_ready);
            chk("busy", busy, exp_busy);
            chk("result_valid", result_valid, exp_valid);
            chk("ballot_reject", ballot_reject, exp_reject);
            if (chk_out) begin
                model_winner(mw, mv);
                chk("winner", winner, mw);
                chk("winner_votes", winner_votes, mv);
                chk("ballots_packed", ballots_packed, model_packed());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        exp_reject = 1'b0;
    endtask

    task automatic idle_cycle(input bit s);
        start = s;
        tick();
        start = 1'b0;
    endtask

    task automatic start_election();
        start = 1'b1;
        tick();
        start = 1'b0;
        clear_votes_model();
        for (int i = 0; i < NV; i++) slot[i] = 2'd0;
        exp_ready = 1'b1;
        exp_busy  = 1'b1;
        chk_out   = 1'b0;
    endtask

    task automatic send_ballot(input int v, input int d);
        logic [3:0] v4;
        logic [1:0] d2;
        v4 = 4'(v);
        d2 = 2'(d);
        ballot_valid = 1'b1;
        ballot_voter = v4;
        ballot_data  = d2;
        tick();
        ballot_valid = 1'b0;
        if (voted[v4]) begin
            exp_reject = 1'b1;
        end else begin
            voted[v4] = 1'b1;
            slot[v4]  = d2;
            cnt[d2]++;
            if (n_voted() == NV) exp_ready = 1'b0;
        end
    endtask

    task automatic finish_compare();
        repeat (4) tick();
        exp_valid = 1'b1;
        chk_out   = 1'b1;
    endtask

    task automatic collect_result(input int delay);
        repeat (delay) tick();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        exp_valid = 1'b0;
        exp_busy  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; ballot_valid = 1'b0;
        ballot_voter = '0; ballot_data = '0; result_ready = 1'b0;
        exp_ready = 0; exp_busy = 0; exp_valid = 0; exp_reject = 0;
        clear_votes_model();
        for (int i = 0; i < NV; i++) slot[i] = 2'd0;
        #12;
        chk("rst_ready", ballot_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_winner", winner, 0);
        chk("rst_packed", ballots_packed, 0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Clear winner: 10x cand 2, 3x cand 1, 2x cand 0, 1x cand 3
        start_election();
        for (int i = 0; i < NV; i++)
            send_ballot(i, (i < 10) ? 2 : (i < 13) ? 1 : (i < 15) ? 0 : 3);
        finish_compare();
        chk("clear_winner", winner, 2);
        chk("clear_votes", winner_votes, 10);
        chk("clear_packed", ballots_packed, 32'hC15AAAAA);
        collect_result(0);

        // Four-way tie resolves to candidate 0
        start_election();
        for (int i = 0; i < NV; i++) send_ballot(i, i % 4);
        finish_compare();
        chk("tie4_winner", winner, 0);
        chk("tie4_votes", winner_votes, 4);
        collect_result(1);

        // Tie between 1 and 2 resolves to 1
        start_election();
        for (int i = 0; i < NV; i++)
            send_ballot(i, (i < 3) ? 0 : (i < 8) ? 1 : (i < 13) ? 2 : 3);
        finish_compare();
        chk("tie2_winner", winner, 1);
        chk("tie2_votes", winner_votes, 5);
        collect_result(2);

        // Duplicates; index 20 wraps to voter 4 on the 4-bit port and is a repeat
        start_election();
        send_ballot(7, 3);
        send_ballot(7, 1);
        chk("dup_reject_pulse", ballot_reject, 1);
        send_ballot(4, 0);
        send_ballot(20, 1);
        chk("dup20_reject_pulse", ballot_reject, 1);
        idle_cycle(1'b1);
        chk("start_ignored_busy", busy, 1);
        for (int i = 0; i < NV; i++) if (i != 4 && i != 7) send_ballot(i, 2);
        finish_compare();
        repeat (10) tick();
        chk("bp_valid", result_valid, 1);
        chk("bp_winner", winner, 2);
        chk("bp_votes", winner_votes, 14);
        chk("dup_slot7", ballots_packed[15:14], 3);
        collect_result(0);
        chk("bp_idle_busy", busy, 0);

        // Abort with a simultaneous ballot, then restart
        start_election();
        for (int i = 0; i < 9; i++) send_ballot(i, 0);
        abort = 1'b1;
        ballot_valid = 1'b1;
        ballot_voter = 4'd9;
        ballot_data  = 2'd1;
        exp_ready = 1'b0;
        tick();
        abort = 1'b0;
        ballot_valid = 1'b0;
        clear_votes_model();
        exp_busy = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_ready", ballot_ready, 0);
        start_election();
        for (int i = 0; i < NV; i++) send_ballot(i, 3);
        finish_compare();
        chk("restart_winner", winner, 3);
        chk("restart_votes", winner_votes, 16);
        collect_result(0);

        // Randomized elections
        for (int e = 0; e < 8; e++) begin
            int tries;
            start_election();
            tries = 0;
            while (n_voted() < NV && tries < 300) begin
                int r;
                r = $urandom_range(0, 9);
                if (r == 0) idle_cycle(1'($urandom_range(0, 1)));
                else send_ballot($urandom_range(0, NV - 1), $urandom_range(0, 3));
                tries++;
            end
            for (int i = 0; i < NV; i++) if (!voted[i]) send_ballot(i, $urandom_range(0, 3));
            finish_compare();
            collect_result($urandom_range(0, 4));
        end

        // Asynchronous reset in the middle of collection
        start_election();
        for (int i = 0; i < 5; i++) send_ballot(i, 1);
        chk_en = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", ballot_ready, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", result_valid, 0);
        chk("midrst_reject", ballot_reject, 0);
        chk("midrst_winner", winner, 0);
        chk("midrst_votes", winner_votes, 0);
        chk("midrst_packed", ballots_packed, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_votes_model();
        for (int i = 0; i < NV; i++) slot[i] = 2'd0;
        exp_ready = 0; exp_busy = 0; exp_valid = 0; exp_reject = 0;
        chk_out = 1'b0;
        chk_en  = 1'b1;
        ballot_valid = 1'b1;
        ballot_voter = 4'd3;
        repeat (3) tick();
        chk("postrst_ready", ballot_ready, 0);
        ballot_valid = 1'b0;
        start_election();
        for (int i = 0; i < NV; i++) send_ballot(NV - 1 - i, (i < 9) ? 1 : 0);
        finish_compare();
        chk("postrst_winner", winner, 1);
        chk("postrst_votes", winner_votes, 9);
        collect_result(0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ballot_tally_collector.md
Name: ballot_tally_collector

Overview:
- Sequential front end for the 16-voter, 4-candidate voting datapath.
- Accepts one 2-bit ballot per handshake, tagged with a voter index, and rejects duplicate voters.
- Assembles the packed 32-bit ballot vector and keeps per-candidate tallies.
- Once all voters have voted, runs an iterative max-search and presents the winner plus the packed vector on a valid/ready result port.

Parameters:
- N_VOTERS, 16, number of voters; must be a power of two, at most 16.
- CAND_W, 2, ballot width in bits; number of candidates is 2**CAND_W = 4.
- CNT_W, 5, tally counter width; must satisfy 2**CNT_W > N_VOTERS.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  opens a new election; sampled only in IDLE.
- abort  input  1  discards the current election from any state.
- ballot_valid  input  1  ballot offered.
- ballot_ready  output  1  ballot accepted when valid and ready are both high.
- ballot_voter  input  4  voter index, 0..N_VOTERS-1.
- ballot_data  input  CAND_W  candidate chosen.
- ballot_reject  output  1  one-cycle pulse: a handshaken ballot was dropped as a duplicate.
- result_valid  output  1  result available.
- result_ready  input  1  result consumed when valid and ready are both high.
- winner  output  CAND_W  winning candidate.
- winner_votes  output  CNT_W  tally of the winner.
- ballots_packed  output  N_VOTERS*CAND_W  voter i occupies bits [2i+1:2i].
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0) forces:
  - state IDLE;
  - all tallies, voted mask, ballots_packed, winner, winner_votes set to 0;
  - ballot_ready, ballot_reject, result_valid, busy set to 0.
- States: IDLE, COLLECT, COMPARE, DONE.
- IDLE:
  - start=1 → COLLECT next cycle.
  - Tallies, voted mask and ballots_packed are cleared on this transition.
- COLLECT:
  - ballot_ready=1.
  - On handshake with voted[ballot_voter]=0:
    - set voted[ballot_voter];
    - write ballot_data into the ballots_packed slot;
    - increment tally[ballot_data].
  - On handshake with voted[ballot_voter]=1:
    - no state change;
    - ballot_reject pulses high the following cycle.
  - ballot_voter >= N_VOTERS is treated as a duplicate (rejected).
  - When the accepting handshake makes the mask all-ones, next state is COMPARE and ballot_ready drops the next cycle.
- COMPARE:
  - Exactly 4 cycles, index k = 0..3, one candidate per cycle.
  - k=0 loads best=0, best_votes=tally[0].
  - For k>0, replace only if tally[k] > best_votes (strict), so ties resolve to the lowest candidate index.
  - After k=3 → DONE.
- DONE:
  - result_valid=1.
  - winner, winner_votes and ballots_packed are held stable while result_valid=1 and result_ready=0.
  - On handshake → IDLE; result_valid falls the next cycle.
  - The outputs keep their last values in IDLE until the next start.
- Latency: last accepting ballot handshake at cycle t → result_valid high at cycle t+5.
- abort=1 in any state:
  - synchronous return to IDLE next cycle;
  - clears tallies and mask;
  - result_valid drops.
  - abort has priority over start, ballot and result handshakes in the same cycle.
- start while not in IDLE is ignored.
- A ballot handshake and a state exit never coincide, because ballot_ready is low outside COLLECT.
- Tally arithmetic is unsigned. Overflow is impossible because the mask limits the count to N_VOTERS.
- Reset asserted mid-election behaves identically to power-on reset.

Test Plan:
- Reset checks:
  - assert rst_n=0 asynchronously mid-COLLECT → all outputs 0 immediately, state IDLE.
  - after rst_n=1 → ballot_ready stays 0 until start.
- Clear winner:
  - start, then voters 0..15 with candidates {2×10, 1×3, 0×2, 3×1} → result_valid at t+5, winner=2, winner_votes=10.
  - ballots_packed matches the per-voter slots.
- Tie resolution:
  - counts {0:4, 1:4, 2:4, 3:4} → winner=0, winner_votes=4.
  - counts {0:3, 1:5, 2:5, 3:3} → winner=1, winner_votes=5.
- Duplicate and out-of-range voters:
  - voter 7 votes 3, then voter 7 votes 1 → second ballot gets ballot_reject pulse, tally[1] unchanged, slot 7 = 3.
  - ballot_voter=20 with N_VOTERS=16 → rejected.
- Result backpressure:
  - hold result_ready=0 for 10 cycles in DONE → result_valid, winner and ballots_packed stable.
  - raise result_ready → IDLE next cycle, busy=0.
- Abort and restart:
  - abort after 9 ballots, asserted together with a ballot_valid → that ballot is not counted, state IDLE.
  - new start plus 16 ballots all for candidate 3 → winner=3, winner_votes=16.
